// File: rtl/fifo_defs_pkg.sv
// ---------------------------------------------------------------------------
// fifo_defs_pkg
// Shared definitions for the parametrised FIFO family.
//   clog2()              constant-foldable ceil(log2(value)), used for sizing
//                        pointers and the occupancy counter
//   FIFO_STD / FIFO_FWFT read-mode encodings for the FWFT parameter
// ---------------------------------------------------------------------------
package fifo_defs_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Smallest n with 2**n >= value; written as a plain loop so it can size
   // ports and localparams at elaboration time.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// ---------------------------------------------------------------------------
// fifo_mem_dp
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are deliberately not reset.
//   clock    write clock
//   wrEn     write strobe, stores wrData at wrAddr on the rising edge
//   wrAddr   write address (0..DEPTH-1)
//   wrData   write data
//   rdAddr   read address (0..DEPTH-1)
//   rdData   contents of mem[rdAddr], combinational
// ---------------------------------------------------------------------------
module fifo_mem_dp #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 60,
   parameter int ADDR_W     = 6
) (
   input  logic                  clock,
   input  logic                  wrEn,
   input  logic [ADDR_W-1:0]     wrAddr,
   input  logic [DATA_WIDTH-1:0] wrData,
   input  logic [ADDR_W-1:0]     rdAddr,
   output logic [DATA_WIDTH-1:0] rdData
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: storage only, no reset, so this maps onto plain flops or
   // distributed RAM. Addresses are kept in range by the controller, which
   // wraps its pointers at DEPTH-1 even when DEPTH is not a power of two.
   always_ff @(posedge clock) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   // Read port is asynchronous so the controller can either register the
   // head word (standard mode) or expose it directly (first-word-fall-through).
   assign rdData = mem[rdAddr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with optional first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds, sticky error flags
// and a synchronous flush. Any DEPTH >= 2 is supported.
//   clk, reset            clock; asynchronous active-high reset
//   wr_en, wr_data        write request and data (ignored while full)
//   rd_en                 read request / head-entry pop in FWFT mode
//   rd_data, rd_valid     read data and its qualifier
//   flush                 empties the FIFO at the next edge
//   clr_err               clears overflow/underflow
//   count                 current occupancy
//   full, empty           occupancy == DEPTH / == 0
//   almost_full           count >= AF_THRESH
//   almost_empty          count <= AE_THRESH
//   overflow, underflow   sticky: write while full / read while empty
// ---------------------------------------------------------------------------
module sync_fifo_param
   import fifo_defs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 60,
   parameter int FWFT       = FIFO_STD,
   parameter int AF_THRESH  = DEPTH - 4,
   parameter int AE_THRESH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_valid,
   input  logic                          flush,
   input  logic                          clr_err,
   output logic [clog2(DEPTH+1)-1:0]     count,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0]      wrPtr;
   logic [PTR_W-1:0]      rdPtr;
   logic [DATA_WIDTH-1:0] headWord;
   logic                  wrAccept;
   logic                  rdAccept;
   logic                  overflowSet;
   logic                  underflowSet;

   // Pointers wrap explicitly at DEPTH-1 rather than by masking, which is
   // what lets DEPTH be any value and not just a power of two.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   // Request qualification. full/empty are taken from the registered count,
   // so a simultaneous write+read at full drops the write and keeps the read,
   // and at empty keeps the write and drops the read. flush overrides both
   // requests and also masks the error conditions for that cycle.
   always_comb begin
      wrAccept     = wr_en && !full  && !flush;
      rdAccept     = rd_en && !empty && !flush;
      overflowSet  = wr_en && full   && !flush;
      underflowSet = rd_en && empty  && !flush;
   end

   // Pointer and occupancy state. A write and read in the same cycle leave
   // the count unchanged; flush returns everything to the empty position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (wrAccept) begin
            wrPtr <= nextPtr(wrPtr);
         end
         if (rdAccept) begin
            rdPtr <= nextPtr(rdPtr);
         end
         if (wrAccept && !rdAccept) begin
            count <= count + 1'b1;
         end else if (rdAccept && !wrAccept) begin
            count <= count - 1'b1;
         end
      end
   end

   // Status flags are purely combinational decodes of the registered count.
   always_comb begin
      full         = (count == CNT_W'(DEPTH));
      empty        = (count == '0);
      almost_full  = (count >= CNT_W'(AF_THRESH));
      almost_empty = (count <= CNT_W'(AE_THRESH));
   end

   // Sticky error flags. A new error in the same cycle as clr_err keeps the
   // flag set so that no event is ever silently lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflowSet  || (overflow  && !clr_err);
         underflow <= underflowSet || (underflow && !clr_err);
      end
   end

   fifo_mem_dp #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) memInst (
      .clock  (clk),
      .wrEn   (wrAccept),
      .wrAddr (wrPtr),
      .wrData (wr_data),
      .rdAddr (rdPtr),
      .rdData (headWord)
   );

   generate
      if (FWFT == FIFO_FWFT) begin : gFwft
         // First-word-fall-through: the head entry is always on rd_data and
         // rd_en merely pops it. A word written into an empty FIFO shows up
         // once the count has registered, one cycle after its write edge.
         assign rd_data  = headWord;
         assign rd_valid = !empty;
      end else begin : gStd
         // Standard mode: the head entry is captured on an accepted read, so
         // data appears one cycle after rd_en. rd_valid is a single-cycle
         // pulse per accepted read; rd_data holds between reads and is left
         // alone by flush.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rdAccept;
               if (rdAccept) begin
                  rd_data <= headWord;
               end
            end
         end
      end
   endgenerate

endmodule
